// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch front end.
//   lc3b_fetch_state : request sequencer states (IDLE / FETCH / DRAIN)
//   PC_STEP_DEFAULT  : default byte increment of the fetch PC per instruction
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } lc3b_fetch_state;

  localparam int unsigned PC_STEP_DEFAULT = 32'd2;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of {pc, instruction}, 2*WIDTH bits each.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   push        : write push_data at the tail (ignored when full without a pop)
//   push_data   : {pc, instruction} entry
//   pop         : drop the head entry (ignored when empty)
//   clear       : flush every entry; wins over push and pop
//   head_data   : registered head entry, holds its last value when empty
//   full, empty : registered occupancy flags
//   count       : registered number of valid entries
module fetch_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [2*WIDTH-1:0]     push_data,
  input  logic                   pop,
  input  logic                   clear,
  output logic [2*WIDTH-1:0]     head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [2*WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] head_q, head_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               pop_ok_s, push_ok_s;

  // Next-state of storage, pointers, occupancy and the registered head.
  always_comb begin
    pop_ok_s  = pop && !empty_q;
    push_ok_s = push && (!full_q || pop_ok_s);
    mem_d     = mem_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    head_d    = head_q;
    if (clear) begin
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1'b1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1'b1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
      // Head is read from the post-update storage so a push into an empty
      // (or just-drained) queue is visible on the very next cycle.
      if (count_d != {CW{1'b0}}) begin
        head_d = mem_d[rd_ptr_d];
      end else begin
        head_d = head_q;
      end
    end
    empty_d = (count_d == {CW{1'b0}});
    full_d  = (count_d == CW'(DEPTH));
  end

  // Queue state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {(2*WIDTH){1'b0}};
      end
      rd_ptr_q <= {PW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      head_q   <= {(2*WIDTH){1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign head_data = head_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues one outstanding
// read at a time, buffers {pc, instruction} pairs and handles redirects.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   mem_read, mem_address : read request (held until mem_resp) and address
//   mem_resp, mem_rdata   : one-cycle read completion and instruction word
//   redirect, redirect_pc : one-cycle branch/jump strobe and new fetch PC
//   ir_valid, ir_ready    : head-of-queue handshake with the consumer
//   ir_out, ir_pc         : head instruction and the address it came from
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] PC_RESET = {WIDTH{1'b0}},
  parameter int unsigned      PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_read,
  output logic [WIDTH-1:0] mem_address,
  input  logic             mem_resp,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             ir_valid,
  input  logic             ir_ready,
  output logic [WIDTH-1:0] ir_out,
  output logic [WIDTH-1:0] ir_pc
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  lc3b_fetch_state    state_q, state_d;
  logic [WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0]   req_addr_q, req_addr_d;
  logic               mem_read_q, mem_read_d;
  logic               push_s, pop_s, room_s;
  logic [2*WIDTH-1:0] head_s;
  logic               fifo_full_s, fifo_empty_s;
  logic [CW-1:0]      fifo_count_s;

  // Both occupancy views must agree there is room; a corrupted count then
  // holds off fetching instead of overrunning the queue.
  assign room_s = !fifo_full_s && (fifo_count_s < CW'(DEPTH));
  // A redirect flushes the queue, so a coincident pop has nothing to take.
  assign pop_s  = !fifo_empty_s && ir_ready && !redirect;

  // Request sequencer next-state, fetch PC and registered read strobe.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    push_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!redirect && room_s) begin
          req_addr_d = fetch_pc_q;
          state_d    = FETCH;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (mem_resp && !redirect) begin
          push_s     = 1'b1;
          fetch_pc_d = fetch_pc_q + WIDTH'(PC_STEP);
          state_d    = IDLE;
        end else if (mem_resp) begin
          state_d = IDLE;
        end else if (redirect) begin
          // The bus request cannot be withdrawn; wait it out and drop it.
          state_d = DRAIN;
        end else begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (mem_resp) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else begin
      fetch_pc_d = fetch_pc_d;
    end
    mem_read_d = (state_d != IDLE);
  end

  // Sequencer state and registered memory-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= PC_RESET;
      req_addr_q <= PC_RESET;
      mem_read_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      mem_read_q <= mem_read_d;
    end
  end

  fetch_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_s),
    .push_data({req_addr_q, mem_rdata}),
    .pop      (pop_s),
    .clear    (redirect),
    .head_data(head_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s),
    .count    (fifo_count_s)
  );

  assign mem_read    = mem_read_q;
  assign mem_address = req_addr_q;
  assign ir_valid    = !fifo_empty_s;
  assign ir_pc       = head_s[2*WIDTH-1:WIDTH];
  assign ir_out      = head_s[WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read;
  logic [15:0] mem_address;
  logic        mem_resp = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [15:0] ir_out;
  logic [15:0] ir_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .WIDTH(16), .DEPTH(4), .PC_RESET(16'h0000), .PC_STEP(2)
  ) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_address(mem_address),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_out(ir_out), .ir_pc(ir_pc)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: delivered-instruction queue plus expected bus activity.
  logic [31:0] mq[$];
  logic [15:0] m_pc, m_addr;
  logic        m_mr, m_poison;
  // Memory responder settings.
  int          mem_cnt = -1;
  int          fixed_lat = 0;
  bit          rand_lat = 1'b0;
  bit          mem_hold = 1'b0;

  function automatic logic [15:0] instr_of(input logic [15:0] a);
    return a + 16'h1000;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc = 16'h0000; m_addr = 16'h0000; m_mr = 1'b0; m_poison = 1'b0;
    mem_cnt = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; ir_ready = 1'b0; mem_resp = 1'b0; mem_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: respond as memory, compare DUT against the model, advance the
  // model with this cycle's inputs. Entered and left at a falling edge.
  task automatic tick();
    int   old_size;
    logic pop, resp;
    resp = 1'b0;
    if (mem_read && !mem_hold) begin
      if (mem_cnt < 0) mem_cnt = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
      if (mem_cnt == 0) begin resp = 1'b1; mem_cnt = -1; end
      else mem_cnt = mem_cnt - 1;
    end else if (!mem_read) begin
      mem_cnt = -1;
    end
    mem_resp  = resp;
    mem_rdata = resp ? instr_of(mem_address) : 16'($urandom);

    checks++;
    if (mem_read !== m_mr) begin
      errors++; $display("FAIL sb_mem_read: got %0b want %0b at %0t", mem_read, m_mr, $time);
    end
    if (m_mr) begin
      checks++;
      if (mem_address !== m_addr) begin
        errors++; $display("FAIL sb_mem_address: got %h want %h at %0t", mem_address, m_addr, $time);
      end
    end
    checks++;
    if (ir_valid !== (mq.size() != 0)) begin
      errors++; $display("FAIL sb_ir_valid: got %0b want %0b at %0t", ir_valid, mq.size() != 0, $time);
    end
    if (mq.size() != 0) begin
      checks++;
      if ({ir_pc, ir_out} !== mq[0]) begin
        errors++; $display("FAIL sb_head: got %h/%h want %h/%h at %0t", ir_pc, ir_out, mq[0][31:16], mq[0][15:0], $time);
      end
    end

    old_size = mq.size();
    pop = (old_size != 0) && ir_ready;
    if (redirect) mq.delete();
    else if (pop) void'(mq.pop_front());
    if (m_mr) begin
      if (resp) begin
        if (!redirect && !m_poison) begin
          mq.push_back({m_addr, instr_of(m_addr)});
          m_pc = m_pc + 16'd2;
        end
        m_mr = 1'b0; m_poison = 1'b0;
      end else if (redirect) begin
        m_poison = 1'b1;
      end
    end else if (old_size < D && !redirect) begin
      m_mr = 1'b1; m_addr = m_pc; m_poison = 1'b0;
    end
    if (redirect) m_pc = redirect_pc;

    @(posedge clk);
    @(negedge clk);
    mem_resp = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 5;
    if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read: got %0b want 0", mem_read); end
    if (mem_address !== 16'h0000) begin errors++; $display("FAIL rst_mem_address: got %h want 0000", mem_address); end
    if (ir_valid !== 1'b0) begin errors++; $display("FAIL rst_ir_valid: got %0b want 0", ir_valid); end
    if (ir_out !== 16'h0000) begin errors++; $display("FAIL rst_ir_out: got %h want 0000", ir_out); end
    if (ir_pc !== 16'h0000) begin errors++; $display("FAIL rst_ir_pc: got %h want 0000", ir_pc); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pairs [3];
    int          got = 0;
    exp_pairs[0] = 32'h0000_1000; exp_pairs[1] = 32'h0002_1002; exp_pairs[2] = 32'h0004_1004;
    do_reset();
    rand_lat = 1'b0; fixed_lat = 0; ir_ready = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i <= 6) begin
        checks++;
        if (mem_read !== ((i % 2) == 1)) begin
          errors++; $display("FAIL seq_bubble: cycle %0d got %0b want %0b", i, mem_read, (i % 2) == 1);
        end
      end
      if (ir_valid && got < 3) begin
        checks++;
        if ({ir_pc, ir_out} !== exp_pairs[got]) begin
          errors++; $display("FAIL seq_pair%0d: got %h/%h want %h", got, ir_pc, ir_out, exp_pairs[got]);
        end
        got++;
      end
    end
    checks++;
    if (got != 3) begin errors++; $display("FAIL seq_count: got %0d want 3", got); end
  endtask

  task automatic test_full();
    logic [15:0] addrs[$];
    logic        prev = 1'b0;
    do_reset();
    rand_lat = 1'b0; fixed_lat = 0; ir_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_read && !prev) addrs.push_back(mem_address);
      prev = mem_read;
    end
    checks += 2;
    if (addrs.size() != 4) begin errors++; $display("FAIL full_req_count: got %0d want 4", addrs.size()); end
    if (mem_read !== 1'b0) begin errors++; $display("FAIL full_idle: got %0b want 0", mem_read); end
    for (int i = 0; i < addrs.size() && i < 4; i++) begin
      checks++;
      if (addrs[i] !== 16'(2 * i)) begin errors++; $display("FAIL full_addr%0d: got %h want %h", i, addrs[i], 16'(2 * i)); end
    end
    addrs.delete();
    ir_ready = 1'b1; tick(); ir_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_read && !prev) addrs.push_back(mem_address);
      prev = mem_read;
    end
    checks++;
    if (addrs.size() != 1) begin errors++; $display("FAIL full_refill_count: got %0d want 1", addrs.size()); end
    else begin
      checks++;
      if (addrs[0] !== 16'h0008) begin errors++; $display("FAIL full_refill_addr: got %h want 0008", addrs[0]); end
    end
  endtask

  task automatic test_redirect_drain();
    int phase = 0;
    int held = 0;
    do_reset();
    rand_lat = 1'b0; fixed_lat = 3; ir_ready = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 16'h3000;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 12 && phase != 2; i++) begin
      if (phase == 0) begin
        if (mem_read) begin
          held++; checks++;
          if (mem_address !== 16'h0000) begin errors++; $display("FAIL drain_addr_hold: got %h want 0000", mem_address); end
        end else phase = 1;
      end else if (mem_read) begin
        checks++; phase = 2;
        if (mem_address !== 16'h3000) begin errors++; $display("FAIL drain_next_addr: got %h want 3000", mem_address); end
      end
      if (phase != 2) begin
        checks++;
        if (ir_valid !== 1'b0) begin errors++; $display("FAIL drain_no_valid: got %0b want 0", ir_valid); end
      end
      tick();
    end
    checks += 2;
    if (phase != 2) begin errors++; $display("FAIL drain_timeout: phase %0d want 2", phase); end
    if (held != 3) begin errors++; $display("FAIL drain_held: got %0d want 3", held); end
  endtask

  task automatic test_same_cycle();
    int n;
    do_reset();
    rand_lat = 1'b0; fixed_lat = 0; ir_ready = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 16'h4000;
    tick();
    redirect = 1'b0;
    checks += 2;
    if (ir_valid !== 1'b0) begin errors++; $display("FAIL same_drop_valid: got %0b want 0", ir_valid); end
    if (mem_read !== 1'b0) begin errors++; $display("FAIL same_idle: got %0b want 0", mem_read); end
    tick();
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 16'h4000) begin
      errors++; $display("FAIL same_next_fetch: got %0b/%h want 1/4000", mem_read, mem_address);
    end
    ir_ready = 1'b0; n = 0;
    while (mq.size() != 3 && n < 30) begin tick(); n++; end
    checks++;
    if (mq.size() != 3) begin errors++; $display("FAIL same_fill_timeout: got %0d want 3", mq.size()); end
    ir_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h5000;
    tick();
    redirect = 1'b0;
    checks++;
    if (ir_valid !== 1'b0) begin errors++; $display("FAIL same_clear_pop: got %0b want 0", ir_valid); end
    n = 0;
    while (!ir_valid && n < 20) begin tick(); n++; end
    checks++;
    if ({ir_pc, ir_out} !== 32'h5000_6000) begin
      errors++; $display("FAIL same_first_after: got %h/%h want 5000/6000", ir_pc, ir_out);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pairs [3];
    int          got = 0;
    exp_pairs[0] = 32'hFFFC_0FFC; exp_pairs[1] = 32'hFFFE_0FFE; exp_pairs[2] = 32'h0000_1000;
    do_reset();
    rand_lat = 1'b1; ir_ready = 1'b1;
    repeat (3) tick();
    redirect = 1'b1; redirect_pc = 16'hFFFC;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 40 && got < 3; i++) begin
      if (ir_valid) begin
        checks++;
        if ({ir_pc, ir_out} !== exp_pairs[got]) begin
          errors++; $display("FAIL wrap_pair%0d: got %h/%h want %h", got, ir_pc, ir_out, exp_pairs[got]);
        end
        got++;
      end
      tick();
    end
    checks++;
    if (got != 3) begin errors++; $display("FAIL wrap_count: got %0d want 3", got); end
  endtask

  task automatic test_random();
    do_reset();
    rand_lat = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      ir_ready    = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 16'hFFFC : 16'($urandom);
      tick();
    end
    redirect = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    rand_lat = 1'b0; fixed_lat = 1; mem_hold = 1'b1; ir_ready = 1'b1;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    checks += 2;
    if (mem_read !== 1'b0) begin errors++; $display("FAIL rstmid_drop: got %0b want 0", mem_read); end
    if (ir_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b want 0", ir_valid); end
    mem_resp = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mem_resp = 1'b0;
    checks += 2;
    if (mem_read !== 1'b1 || mem_address !== 16'h0000) begin
      errors++; $display("FAIL rstmid_restart: got %0b/%h want 1/0000", mem_read, mem_address);
    end
    if (ir_valid !== 1'b0) begin errors++; $display("FAIL rstmid_late_resp: got %0b want 0", ir_valid); end
    model_reset();
    m_mr = 1'b1; m_addr = 16'h0000; mem_hold = 1'b0;
    while (!ir_valid && n < 10) begin tick(); n++; end
    checks++;
    if ({ir_pc, ir_out} !== 32'h0000_1000) begin
      errors++; $display("FAIL rstmid_first: got %h/%h want 0000/1000", ir_pc, ir_out);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_full();
    test_redirect_drain();
    test_same_cycle();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
